// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing, colour codes and their DAC colours.
// Used by the scan driver, the colour LUT and any later overlay renderer.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_PIPE    = 2;

  localparam logic [2:0] CC_START = 3'b000;
  localparam logic [2:0] CC_OBJ   = 3'b001;
  localparam logic [2:0] CC_BLOCK = 3'b010;
  localparam logic [2:0] CC_BG    = 3'b011;
  localparam logic [2:0] CC_WIN   = 3'b100;
  localparam logic [2:0] CC_LOSS  = 3'b101;

  localparam logic [23:0] RGB_START = 24'h0000FF;
  localparam logic [23:0] RGB_OBJ   = 24'h000000;
  localparam logic [23:0] RGB_BLOCK = 24'hFF0000;
  localparam logic [23:0] RGB_BG    = 24'hFFFFFF;
  localparam logic [23:0] RGB_WIN   = 24'h00FF00;
  localparam logic [23:0] RGB_LOSS  = 24'hFF8000;
  localparam logic [23:0] RGB_IDLE  = 24'h000000;

  // Sync/blank bundle carried through the alignment pipe (sync active-low).
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_color_lut.sv
// Combinational map from the game's 3-bit colour code to 24-bit RGB.
// Unused codes (reset/idle) fall through to black.
module vga_color_lut
  import vga_pkg::*;
(
  input  logic [2:0]  code,
  output logic [23:0] rgb
);

  always_comb begin
    rgb = RGB_IDLE;
    case (code)
      CC_START: rgb = RGB_START;
      CC_OBJ:   rgb = RGB_OBJ;
      CC_BLOCK: rgb = RGB_BLOCK;
      CC_BG:    rgb = RGB_BG;
      CC_WIN:   rgb = RGB_WIN;
      CC_LOSS:  rgb = RGB_LOSS;
      default:  rgb = RGB_IDLE;
    endcase
  end

endmodule

// File: rtl/vga_scan_driver.sv
// 640x480 raster scan generator and DAC driver; sync/blank are delayed by
// PIPE pixel ticks so they line up with the externally registered colour.
module vga_scan_driver
  import vga_pkg::timing_t, vga_pkg::TIMING_IDLE;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CLK_DIV  = vga_pkg::DEF_CLK_DIV,
  parameter int PIPE     = vga_pkg::DEF_PIPE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] color,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_en,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] X_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       x_reg, x_next, y_reg, y_next;
  logic             tick;
  timing_t          raw;
  timing_t          aligned;
  logic [23:0]      lut_rgb;
  logic             hsync_reg, vsync_reg, blank_n_reg;
  logic [23:0]      rgb_reg;

  // Gated by rst so a divide-by-one build still shows no tick during reset.
  assign tick = rst & (div_reg == DIV_LAST);

  always_comb begin
    div_next = tick ? '0 : div_reg + 1'b1;
    x_next   = x_reg;
    y_next   = y_reg;
    if (tick) begin
      if (x_reg == X_LAST) begin
        x_next = '0;
        y_next = (y_reg == Y_LAST) ? '0 : y_reg + 10'd1;
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
    end else begin
      div_reg <= div_next;
      x_reg   <= x_next;
      y_reg   <= y_next;
    end
  end

  always_comb begin
    raw     = TIMING_IDLE;
    raw.hs  = !((x_reg >= HS_FIRST) && (x_reg <= HS_LAST));
    raw.vs  = !((y_reg >= VS_FIRST) && (y_reg <= VS_LAST));
    raw.act = (x_reg < X_ACT) && (y_reg < Y_ACT);
  end

  generate
    if (PIPE == 0) begin : g_nopipe
      assign aligned = raw;
    end else begin : g_pipe
      timing_t stage_reg [PIPE];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPE; i++) stage_reg[i] <= TIMING_IDLE;
        end else if (tick) begin
          stage_reg[0] <= raw;
          for (int i = 1; i < PIPE; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign aligned = stage_reg[PIPE-1];
    end
  endgenerate

  vga_color_lut u_lut (
    .code (color),
    .rgb  (lut_rgb)
  );

  // All five DAC-side outputs update on the same tick so they stay coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_reg   <= 1'b1;
      vsync_reg   <= 1'b1;
      blank_n_reg <= 1'b0;
      rgb_reg     <= '0;
    end else if (tick) begin
      hsync_reg   <= aligned.hs;
      vsync_reg   <= aligned.vs;
      blank_n_reg <= aligned.act;
      rgb_reg     <= aligned.act ? lut_rgb : 24'h000000;
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign pix_en      = tick;
  assign frame_start = tick && (x_reg == 10'd0) && (y_reg == 10'd0);
  assign vga_clk     = rst & (div_reg >= DIV_HALF);
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign blank_n     = blank_n_reg;
  assign sync_n      = 1'b0;
  assign r           = rgb_reg[23:16];
  assign g           = rgb_reg[15:8];
  assign b           = rgb_reg[7:0];

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver: full-width lines, shortened frame height
// so whole frames fit in a short run.
module tb_vga_scan_driver;

  localparam int PIPE = 2;
  localparam int CDIV = 2;
  localparam int HT   = 800;
  localparam int VA   = 3;
  localparam int VFP  = 1;
  localparam int VSY  = 2;
  localparam int VBP  = 1;
  localparam int VT   = VA + VFP + VSY + VBP;
  localparam int FT   = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] color;
  logic [9:0] x, y;
  logic       pix_en, frame_start, vga_clk, hsync, vsync, blank_n, sync_n;
  logic [7:0] r, g, b;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [2:0] color_drv = 3'b011;
  int         mode      = 0;
  logic [2:0] gen0 = 3'b011, gen1 = 3'b011;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in colour generator: two registered stages behind x.
  always @(posedge clk) begin
    if (pix_en) begin
      gen0 <= (x >= 10'd100 && x <= 10'd139) ? 3'b010 : 3'b011;
      gen1 <= gen0;
    end
  end
  assign color = (mode == 2) ? gen1 : color_drv;

  vga_scan_driver #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CLK_DIV(CDIV), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst), .color(color), .x(x), .y(y),
    .pix_en(pix_en), .frame_start(frame_start), .vga_clk(vga_clk),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
    .r(r), .g(g), .b(b)
  );

  // Position of the pixel currently shown at the outputs.
  function automatic void aligned_pos(input int xx, input int yy, output int ax, output int ay);
    int lin;
    lin = yy * HT + xx - (PIPE + 1);
    if (lin < 0) lin += FT;
    ax = lin % HT;
    ay = lin / HT;
  endfunction

  task automatic next_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_en && n < 8);
    compared++;
    if (pix_en !== 1'b1) begin
      mismatched++;
      $display("FAIL tick_timeout: pix_en=%b required 1", pix_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    color_drv = 3'b011;
    repeat (3) @(negedge clk);
    compared++; if (x !== 10'd0) begin mismatched++; $display("FAIL rst_x: got %0d want 0", x); end
    compared++; if (y !== 10'd0) begin mismatched++; $display("FAIL rst_y: got %0d want 0", y); end
    compared++; if (pix_en !== 1'b0) begin mismatched++; $display("FAIL rst_pix_en: got %b want 0", pix_en); end
    compared++; if (frame_start !== 1'b0) begin mismatched++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    compared++; if (vga_clk !== 1'b0) begin mismatched++; $display("FAIL rst_vga_clk: got %b want 0", vga_clk); end
    compared++; if ({hsync, vsync, blank_n} !== 3'b110) begin mismatched++; $display("FAIL rst_sync: got hs/vs/bl=%b want 110", {hsync, vsync, blank_n}); end
    compared++; if ({r, g, b} !== 24'h000000) begin mismatched++; $display("FAIL rst_rgb: got %h want 000000", {r, g, b}); end
    compared++; if (sync_n !== 1'b0) begin mismatched++; $display("FAIL sync_n: got %b want 0", sync_n); end
    rst = 1'b1;
    @(negedge clk);
    compared++; if (pix_en !== 1'b1) begin mismatched++; $display("FAIL first_pix_en: got %b want 1", pix_en); end
    compared++; if (frame_start !== 1'b1) begin mismatched++; $display("FAIL first_frame_start: got %b want 1", frame_start); end
    compared++; if (vga_clk !== 1'b1) begin mismatched++; $display("FAIL vga_clk_high: got %b want 1", vga_clk); end
    compared++; if ({hsync, blank_n, r, g, b} !== 26'h2000000) begin mismatched++; $display("FAIL tick0_out: got hs=%b bl=%b rgb=%h want 1 0 000000", hsync, blank_n, {r, g, b}); end
    @(negedge clk);
    compared++; if (x !== 10'd1 || pix_en !== 1'b0 || vga_clk !== 1'b0) begin mismatched++; $display("FAIL after_first_tick: got x=%0d pix_en=%b vga_clk=%b want 1 0 0", x, pix_en, vga_clk); end
    for (int k = 1; k <= PIPE; k++) begin
      next_tick();
      compared++;
      if (hsync !== 1'b1 || blank_n !== 1'b0 || {r, g, b} !== 24'h000000) begin
        mismatched++;
        $display("FAIL early_tick%0d: got hs=%b bl=%b rgb=%h want 1 0 000000", k, hsync, blank_n, {r, g, b});
      end
    end
    next_tick();
    compared++; if (blank_n !== 1'b1 || {r, g, b} !== 24'hFFFFFF) begin mismatched++; $display("FAIL first_visible: got bl=%b rgb=%h want 1 FFFFFF", blank_n, {r, g, b}); end
  endtask

  task automatic test_hsync_line();
    int n = 0, t0, low = 0, fall_x = -1;
    logic prev;
    while (x !== 10'd0 && n < HT + 2) begin next_tick(); n++; end
    t0 = cyc;
    prev = hsync;
    for (int i = 0; i < HT; i++) begin
      if (!hsync) low++;
      if (prev && !hsync) fall_x = int'(x);
      prev = hsync;
      next_tick();
    end
    compared++; if (x !== 10'd0) begin mismatched++; $display("FAIL line_wrap_x: got %0d want 0", x); end
    compared++; if (cyc - t0 !== 2 * HT) begin mismatched++; $display("FAIL line_period: got %0d clks want %0d", cyc - t0, 2 * HT); end
    compared++; if (low !== 96) begin mismatched++; $display("FAIL hsync_width: got %0d ticks want 96", low); end
    compared++; if (fall_x !== 656 + PIPE + 1) begin mismatched++; $display("FAIL hsync_fall_x: got %0d want %0d", fall_x, 656 + PIPE + 1); end
  endtask

  task automatic test_frame();
    int n = 0, t0, vs_low = 0, max_x = 0, max_y = 0;
    int err_h = 0, err_v = 0, err_b = 0, err_fs = 0, ax, ay;
    logic eh, ev, eb;
    while (frame_start !== 1'b1 && n < FT + 2) begin next_tick(); n++; end
    t0 = cyc;
    for (int i = 0; i < FT; i++) begin
      aligned_pos(int'(x), int'(y), ax, ay);
      eh = !(ax >= 656 && ax <= 751);
      ev = !(ay >= VA + VFP && ay <= VA + VFP + VSY - 1);
      eb = (ax < 640) && (ay < VA);
      if (hsync !== eh) err_h++;
      if (vsync !== ev) err_v++;
      if (blank_n !== eb) err_b++;
      if (frame_start !== (x == 10'd0 && y == 10'd0)) err_fs++;
      if (!vsync) vs_low++;
      if (int'(x) > max_x) max_x = int'(x);
      if (int'(y) > max_y) max_y = int'(y);
      next_tick();
    end
    compared++; if (frame_start !== 1'b1) begin mismatched++; $display("FAIL frame_wrap: got frame_start=%b want 1", frame_start); end
    compared++; if (cyc - t0 !== 2 * FT) begin mismatched++; $display("FAIL frame_period: got %0d clks want %0d", cyc - t0, 2 * FT); end
    compared++; if (vs_low * CDIV !== 2 * HT * VSY) begin mismatched++; $display("FAIL vsync_width: got %0d clks want %0d", vs_low * CDIV, 2 * HT * VSY); end
    compared++; if (max_x !== HT - 1 || max_y !== VT - 1) begin mismatched++; $display("FAIL xy_range: got max x=%0d y=%0d want %0d %0d", max_x, max_y, HT - 1, VT - 1); end
    compared++; if (err_h !== 0) begin mismatched++; $display("FAIL hsync_align: got %0d bad ticks want 0", err_h); end
    compared++; if (err_v !== 0) begin mismatched++; $display("FAIL vsync_align: got %0d bad ticks want 0", err_v); end
    compared++; if (err_b !== 0) begin mismatched++; $display("FAIL blank_align: got %0d bad ticks want 0", err_b); end
    compared++; if (err_fs !== 0) begin mismatched++; $display("FAIL frame_start_pos: got %0d bad ticks want 0", err_fs); end
  endtask

  task automatic test_white();
    int err = 0, white = 0, ax, ay;
    logic [23:0] exp_rgb;
    color_drv = 3'b011;
    next_tick();
    for (int i = 0; i < FT; i++) begin
      aligned_pos(int'(x), int'(y), ax, ay);
      exp_rgb = (ax < 640 && ay < VA) ? 24'hFFFFFF : 24'h000000;
      if ({r, g, b} !== exp_rgb) err++;
      if ({r, g, b} === 24'hFFFFFF) white++;
      next_tick();
    end
    compared++; if (err !== 0) begin mismatched++; $display("FAIL white_gating: got %0d bad ticks want 0", err); end
    compared++; if (white !== 640 * VA) begin mismatched++; $display("FAIL white_count: got %0d want %0d", white, 640 * VA); end
  endtask

  task automatic test_red_span();
    int err = 0, red = 0, lo = 9999, hi = -1, ax, ay;
    logic [23:0] exp_rgb;
    mode = 2;
    repeat (PIPE + 2) next_tick();
    for (int i = 0; i < FT; i++) begin
      aligned_pos(int'(x), int'(y), ax, ay);
      if (ax < 640 && ay < VA)
        exp_rgb = (ax >= 100 && ax <= 139) ? 24'hFF0000 : 24'hFFFFFF;
      else
        exp_rgb = 24'h000000;
      if ({r, g, b} !== exp_rgb) err++;
      if ({r, g, b} === 24'hFF0000) begin
        red++;
        if (ax < lo) lo = ax;
        if (ax > hi) hi = ax;
      end
      next_tick();
    end
    mode = 0;
    compared++; if (err !== 0) begin mismatched++; $display("FAIL red_pixels: got %0d bad ticks want 0", err); end
    compared++; if (red !== 40 * VA) begin mismatched++; $display("FAIL red_count: got %0d want %0d", red, 40 * VA); end
    compared++; if (lo !== 100 || hi !== 139) begin mismatched++; $display("FAIL red_edges: got %0d..%0d want 100..139", lo, hi); end
  endtask

  task automatic test_midframe_reset();
    int n = 0;
    color_drv = 3'b011;
    while (!(x === 10'd300 && y === 10'd1) && n < FT + 2) begin next_tick(); n++; end
    compared++; if (x !== 10'd300 || y !== 10'd1 || blank_n !== 1'b1) begin mismatched++; $display("FAIL pre_reset_pos: got x=%0d y=%0d bl=%b want 300 1 1", x, y, blank_n); end
    #2 rst = 1'b0;
    #1;
    compared++; if (x !== 10'd0 || y !== 10'd0) begin mismatched++; $display("FAIL async_rst_xy: got %0d,%0d want 0,0", x, y); end
    compared++; if (pix_en !== 1'b0 || vga_clk !== 1'b0 || frame_start !== 1'b0) begin mismatched++; $display("FAIL async_rst_ctl: got pe=%b vc=%b fs=%b want 0 0 0", pix_en, vga_clk, frame_start); end
    compared++; if ({hsync, vsync, blank_n} !== 3'b110 || {r, g, b} !== 24'h000000) begin mismatched++; $display("FAIL async_rst_out: got hs/vs/bl=%b rgb=%h want 110 000000", {hsync, vsync, blank_n}, {r, g, b}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (x !== 10'd0 || blank_n !== 1'b0) begin mismatched++; $display("FAIL rst_hold: got x=%0d bl=%b want 0 0", x, blank_n); end
    rst = 1'b1;
    @(negedge clk);
    compared++; if (pix_en !== 1'b1 || frame_start !== 1'b1 || x !== 10'd0 || y !== 10'd0) begin mismatched++; $display("FAIL restart: got pe=%b fs=%b x=%0d y=%0d want 1 1 0 0", pix_en, frame_start, x, y); end
  endtask

  task automatic test_color_sweep();
    logic [23:0] table_rgb [8];
    int n = 0;
    table_rgb[0] = 24'h0000FF; table_rgb[1] = 24'h000000;
    table_rgb[2] = 24'hFF0000; table_rgb[3] = 24'hFFFFFF;
    table_rgb[4] = 24'h00FF00; table_rgb[5] = 24'hFF8000;
    table_rgb[6] = 24'h000000; table_rgb[7] = 24'h000000;
    while (x !== 10'd4 && n < 20) begin next_tick(); n++; end
    for (int c = 0; c < 8; c++) begin
      color_drv = 3'(c);
      next_tick();
      compared++;
      if ({r, g, b} !== table_rgb[c] || blank_n !== 1'b1) begin
        mismatched++;
        $display("FAIL code_%0d: got rgb=%h bl=%b want %h 1", c, {r, g, b}, blank_n, table_rgb[c]);
      end
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hsync_line();
    test_frame();
    test_white();
    test_red_span();
    test_midframe_reset();
    test_color_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- Raster-side counterpart of the game's pixel-colour generator. Produces the 640x480@60 scan position (x, y) that the colour generator consumes.
- Takes back that generator's registered 3-bit colour code and drives the VGA DAC: 8-bit R/G/B, hsync, vsync, blank_n, sync_n, vga_clk.
- Delays sync and blank to match the colour path latency, so the colour lands on the pixel that requested it.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync pulse width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel tick (50 MHz clk -> 25 MHz pixel)
- PIPE, 2, colour-code latency in pixel ticks from x/y change to a valid colour

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- color  in  3  colour code from the pixel-colour generator
- x  out  10  horizontal scan counter, 0..799
- y  out  10  vertical scan counter, 0..524
- pix_en  out  1  one-clk pulse marking each pixel tick
- frame_start  out  1  one-clk pulse on the pixel tick where x=0, y=0
- vga_clk  out  1  pixel clock to the DAC; toggles so the rising edge is mid-pixel
- hsync  out  1  active-low horizontal sync, aligned to r/g/b
- vsync  out  1  active-low vertical sync, aligned to r/g/b
- blank_n  out  1  high only while the aligned pixel is in the active area
- sync_n  out  1  tied 0 (no sync-on-green)
- r, g, b  out  8 each  DAC colour

Behaviour:
- Reset (rst=0, async): all of the following hold until the first clk edge with rst=1.
  - div counter=0, x=0, y=0, pix_en=0, frame_start=0, vga_clk=0
  - hsync=1, vsync=1, blank_n=0
  - r=g=b=0
  - delay pipes cleared to inactive: hsync=1, vsync=1, active=0
- Pixel tick:
  - div counter counts 0..CLK_DIV-1.
  - pix_en=1 in the cycle where div=CLK_DIV-1.
  - vga_clk=0 while div < CLK_DIV/2, otherwise 1.
- Counters advance only when pix_en=1:
  - x wraps 799->0; when x wraps, y increments.
  - y wraps 524->0 when x wraps at y=524.
  - Line total = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - Frame total = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Raw timing, decoded from the current x/y:
  - raw_hs=0 for x in [656,751].
  - raw_vs=0 for y in [490,491].
  - raw_act=1 for x<640 and y<480.
- Alignment: raw_hs, raw_vs and raw_act pass through a PIPE-deep shift register clocked on pix_en. Outputs are taken from the last stage.
- Colour stage, registered on pix_en:
  - If the delayed act=1, r/g/b are taken from the decode of color.
  - Otherwise r/g/b=0.
  - hsync, vsync and blank_n are registered in the same edge, so all five outputs change together.
- Colour decode (RGB hex):
  - 000 start screen -> 0000FF
  - 001 ball/paddle -> 000000
  - 010 block -> FF0000
  - 011 background -> FFFFFF
  - 100 win -> 00FF00
  - 101 loss -> FF8000
  - 110, 111 (reset/idle) -> 000000
- frame_start: asserted in the same cycle as pix_en when x=0 and y=0, i.e. before the counters advance.
- Boundary cases:
  - color changes between pixel ticks are ignored; only the value at the pix_en edge is sampled.
  - x/y stay valid and stable across the CLK_DIV cycles of one pixel.
  - Reset mid-frame restarts at x=0, y=0; the first frame_start occurs on the first pix_en after release.
  - PIPE=0 is legal: pure combinational alignment with one register stage at the outputs.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants (H_*, V_*)
  - derived totals and sync start/end positions
  - colour-code localparams CC_START, CC_OBJ, CC_BLOCK, CC_BG, CC_WIN, CC_LOSS
  - 24-bit RGB constants for each code
- One natural sub-module: vga_color_lut, a pure combinational map from the 3-bit code to 24-bit RGB. It is shared with any future overlay or score renderer.

Test Plan:
- Reset, then release -> first pix_en on the 2nd clk; x=1 after that edge; hsync=1, blank_n=0, rgb=0 for the first PIPE+1 pixel ticks.
- Free run one line -> hsync low for exactly 96 pix_en ticks, with its falling edge PIPE+1 ticks after x=656; line period 1600 clks.
- Free run one frame -> vsync low for exactly 2 lines (3200 clks); frame_start period 840000 clks; y never exceeds 524 and x never exceeds 799.
- Drive color=011 constant -> rgb=FFFFFF only while blank_n=1; rgb=000000 while blank_n=0 (including x 640..799); exactly 640 white ticks per active line.
- Drive color as a function of delayed x (010 for x=100..139, else 011) -> red spans pixels 100..139 at the outputs with no off-by-one at either edge, confirming PIPE alignment.
- Assert rst at x=300, y=200 for 3 clks -> all outputs return to reset values asynchronously; after release the scan restarts at 0,0; sweep codes 000..111 -> decoded RGB matches the table, with 110/111 giving black.
